// File: rtl/min_max_decoder_if.sv
// Bus between the LED-bar source and min_max_decoder.
// Carries the sampled LED bar plus strobe (master side) and the decoded result (slave side).
interface min_max_decoder_if #(
  parameter int unsigned VALSIZE = 4
);
  localparam int unsigned N = 2**VALSIZE;

  logic [N-1:0]       leds_i;
  logic               sample_i;
  logic [VALSIZE-1:0] min_o;
  logic [VALSIZE-1:0] value_o;
  logic [VALSIZE-1:0] max_o;
  logic [1:0]         mode_o;
  logic               valid_o;
  logic               overrun_o;

  modport master (
    output leds_i, sample_i,
    input  min_o, value_o, max_o, mode_o, valid_o, overrun_o
  );

  modport slave (
    input  leds_i, sample_i,
    output min_o, value_o, max_o, mode_o, valid_o, overrun_o
  );
endinterface

// File: rtl/min_max_decoder.sv
// min_max_decoder: recovers min/value/max from two phases of a blinking LED bar.
// Phase A and phase B are captured on successive strobes, then scanned one bit
// per cycle by a segment tracker (steady run followed by an optional blink run).
// Optional build macro MIN_MAX_DEC_OVERRUN_EN adds a sticky overrun flag for
// strobes arriving while the decoder is busy; without it overrun_o is tied 0.
module min_max_decoder #(
  parameter int unsigned VALSIZE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  min_max_decoder_if.slave  bus
);
  localparam int unsigned N  = 2**VALSIZE;
  localparam int unsigned IW = VALSIZE + 1;

  localparam logic [1:0] MODE_BAR     = 2'b00;
  localparam logic [1:0] MODE_INVALID = 2'b01;
  localparam logic [1:0] MODE_ALL_OFF = 2'b10;
  localparam logic [1:0] MODE_ALL_ON  = 2'b11;

  typedef enum logic [1:0] {IDLE, CAP_B, SCAN, REPORT} state_e;
  typedef enum logic [1:0] {SEG_NONE, SEG_STEADY, SEG_BLINK, SEG_DONE} seg_e;

  state_e state_q, state_d;

  logic [N-1:0]       a_q, b_q;
  logic [IW-1:0]      idx_q;
  seg_e               seg_q, seg_d;
  logic               err_q, err_d;
  logic [VALSIZE-1:0] lo_q, lo_d, hi_q, hi_d, kmax_q, kmax_d;
  logic               kseen_q, kseen_d;
  logic               kphase_q, kphase_d;

  logic [VALSIZE-1:0] bit_pos_c;
  logic               s_bit_c, k_bit_c, a_bit_c;
  logic               last_bit_c;

  logic [1:0]         res_mode_c;
  logic [VALSIZE-1:0] res_min_c, res_val_c, res_max_c;

  logic [VALSIZE-1:0] min_q, value_q, max_q;
  logic [1:0]         mode_q;
  logic               valid_q;

  assign last_bit_c = (state_q == SCAN) && (idx_q == IW'(N - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; strobes in SCAN/REPORT are ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.sample_i) state_d = CAP_B;
      CAP_B:   if (bus.sample_i) state_d = SCAN;
      SCAN:    if (last_bit_c)   state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Segment tracker: steady run first, then optional same-phase blink run, then nothing
  always_comb begin
    seg_d     = seg_q;
    err_d     = err_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    kmax_d    = kmax_q;
    kseen_d   = kseen_q;
    kphase_d  = kphase_q;
    bit_pos_c = idx_q[VALSIZE-1:0];
    a_bit_c   = a_q[bit_pos_c];
    s_bit_c   = a_q[bit_pos_c] & b_q[bit_pos_c];
    k_bit_c   = a_q[bit_pos_c] ^ b_q[bit_pos_c];
    if (state_q == SCAN) begin
      unique case (seg_q)
        SEG_NONE: begin
          if (s_bit_c) begin
            seg_d = SEG_STEADY;
            lo_d  = bit_pos_c;
            hi_d  = bit_pos_c;
          end else if (k_bit_c) begin
            err_d = 1'b1;
          end
        end
        SEG_STEADY: begin
          if (s_bit_c) begin
            hi_d = bit_pos_c;
          end else if (k_bit_c) begin
            seg_d    = SEG_BLINK;
            kseen_d  = 1'b1;
            kmax_d   = bit_pos_c;
            kphase_d = a_bit_c;
          end else begin
            seg_d = SEG_DONE;
          end
        end
        SEG_BLINK: begin
          if (s_bit_c) begin
            err_d = 1'b1;
          end else if (k_bit_c) begin
            kmax_d = bit_pos_c;
            if (a_bit_c != kphase_q) err_d = 1'b1;
          end else begin
            seg_d = SEG_DONE;
          end
        end
        SEG_DONE: begin
          if (s_bit_c || k_bit_c) err_d = 1'b1;
        end
        default: seg_d = SEG_NONE;
      endcase
    end
  end

  // Final classification from the tracker including the bit being scanned now
  always_comb begin
    res_mode_c = MODE_INVALID;
    res_min_c  = '0;
    res_val_c  = '0;
    res_max_c  = '0;
    if ((&a_q) && (&b_q)) begin
      res_mode_c = MODE_ALL_ON;
    end else if ((a_q == '0) && (b_q == '0)) begin
      res_mode_c = MODE_ALL_OFF;
    end else if (!err_d && (seg_d != SEG_NONE)) begin
      res_mode_c = MODE_BAR;
      res_min_c  = lo_d;
      res_val_c  = hi_d;
      res_max_c  = kseen_d ? kmax_d : hi_d;
    end
  end

  // Phase capture, scan index and tracker state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_NONE;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      kmax_q   <= '0;
      kseen_q  <= 1'b0;
      kphase_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.sample_i) a_q <= bus.leds_i;
        CAP_B: begin
          if (bus.sample_i) begin
            b_q      <= bus.leds_i;
            idx_q    <= '0;
            seg_q    <= SEG_NONE;
            err_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            kmax_q   <= '0;
            kseen_q  <= 1'b0;
            kphase_q <= 1'b0;
          end
        end
        SCAN: begin
          idx_q    <= idx_q + IW'(1);
          seg_q    <= seg_d;
          err_q    <= err_d;
          lo_q     <= lo_d;
          hi_q     <= hi_d;
          kmax_q   <= kmax_d;
          kseen_q  <= kseen_d;
          kphase_q <= kphase_d;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded on the last scan bit, valid pulses during REPORT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q   <= '0;
      value_q <= '0;
      max_q   <= '0;
      mode_q  <= MODE_ALL_OFF;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (last_bit_c) begin
        min_q   <= res_min_c;
        value_q <= res_val_c;
        max_q   <= res_max_c;
        mode_q  <= res_mode_c;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.min_o   = min_q;
  assign bus.value_o = value_q;
  assign bus.max_o   = max_q;
  assign bus.mode_o  = mode_q;
  assign bus.valid_o = valid_q;

`ifdef MIN_MAX_DEC_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: a strobe arrived while scanning or reporting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                                     overrun_q <= 1'b0;
    else if (bus.sample_i && ((state_q == SCAN) || (state_q == REPORT))) overrun_q <= 1'b1;
  end

  assign bus.overrun_o = overrun_q;
`else
  assign bus.overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_min_max_decoder.sv
// Testbench for min_max_decoder (VALSIZE=4): directed pinned cases, reset abort,
// overrun strobes and randomized bar patterns against a behavioural model.
module tb_min_max_decoder;
  localparam int unsigned VALSIZE = 4;
  localparam int unsigned N = 16;
  localparam int BIG = 32'h7fffffff;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] mn;
    logic [3:0] val;
    logic [3:0] mx;
  } res_t;

  typedef struct packed {
    int   due;
    res_t res;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  bit   checking;
  int   ov_due;
  int   last_valid_cyc;
  exp_t q[$];
  res_t held;

  min_max_decoder_if #(.VALSIZE(VALSIZE)) bus ();

  min_max_decoder #(.VALSIZE(VALSIZE)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mask(input int lo, input int hi);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // Reference: classify the two phases directly from the bar rules
  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    logic [N-1:0] s, k, all1;
    int lo, hi, klo, khi;
    bit ok;
    all1 = '1;
    r = '{mode: 2'b01, mn: 4'd0, val: 4'd0, mx: 4'd0};
    s = a & b;
    k = a ^ b;
    if (a == all1 && b == all1) r.mode = 2'b11;
    else if (a == '0 && b == '0) r.mode = 2'b10;
    else if (s != '0) begin
      lo = -1; hi = -1; klo = -1; khi = -1;
      for (int i = 0; i < N; i++) begin
        if (s[i]) begin if (lo < 0) lo = i; hi = i; end
        if (k[i]) begin if (klo < 0) klo = i; khi = i; end
      end
      ok = (s == mask(lo, hi));
      if (k != '0)
        ok = ok && (klo == hi + 1) && (k == mask(klo, khi)) && (((k & a) == k) || ((k & a) == '0));
      if (ok) begin
        r.mode = 2'b00;
        r.mn   = 4'(lo);
        r.val  = 4'(hi);
        r.mx   = (k == '0) ? 4'(hi) : 4'(khi);
      end
    end
    return r;
  endfunction

  // Every-cycle compare of all outputs against the model's held result
  always @(negedge clk) begin
    if (checking) begin
      bit ev;
      bit eov;
      if (!rst_n) begin
        held = '{mode: 2'b10, mn: 4'd0, val: 4'd0, mx: 4'd0};
        ev = 1'b0;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
          held = q[0].res;
          void'(q.pop_front());
        end
      end
      if (bus.valid_o) last_valid_cyc = cyc;
`ifdef MIN_MAX_DEC_OVERRUN_EN
      eov = rst_n && (cyc >= ov_due);
`else
      eov = 1'b0;
`endif
      chk("valid_o", int'(bus.valid_o), int'(ev));
      chk("mode_o", int'(bus.mode_o), int'(held.mode));
      chk("min_o", int'(bus.min_o), int'(held.mn));
      chk("value_o", int'(bus.value_o), int'(held.val));
      chk("max_o", int'(bus.max_o), int'(held.mx));
      chk("overrun_o", int'(bus.overrun_o), int'(eov));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] v, output int c);
    bus.leds_i   = v;
    bus.sample_i = 1'b1;
    c = cyc;
    step();
    bus.sample_i = 1'b0;
    bus.leds_i   = N'($urandom);
  endtask

  // One A/B pair; optional extra strobe while busy; returns after REPORT
  task automatic run_pair(input logic [N-1:0] a, input logic [N-1:0] b, input bit ovr, output int c);
    int due, c2, r;
    exp_t e;
    strobe(a, c2);
    repeat ($urandom_range(0, 3)) step();
    strobe(b, c);
    due = c + N + 1;
    e.due = due;
    e.res = model(a, b);
    q.push_back(e);
    if (ovr) begin
      r = $urandom_range(0, N);
      repeat (r) step();
      strobe(N'($urandom), c2);
      if (c2 + 1 < ov_due) ov_due = c2 + 1;
    end
    while (cyc <= due) step();
  endtask

  task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] md,
                          input int mn, input int val, input int mx);
    int c;
    res_t m;
    m = model(a, b);
    chk("model_mode", int'(m.mode), int'(md));
    chk("model_max", int'(m.mx), mx);
    run_pair(a, b, 1'b0, c);
    chk("latency", last_valid_cyc - c, N + 1);
    chk("lit_mode", int'(bus.mode_o), int'(md));
    chk("lit_min", int'(bus.min_o), mn);
    chk("lit_value", int'(bus.value_o), val);
    chk("lit_max", int'(bus.max_o), mx);
  endtask

  // Random pair biased toward well-formed bars, sometimes corrupted or fully random
  task automatic gen_pair(output logic [N-1:0] a, output logic [N-1:0] b);
    int lo, hi, kh, sel;
    logic [N-1:0] s, k;
    sel = $urandom_range(0, 9);
    if (sel < 2) begin
      a = N'($urandom);
      b = ($urandom_range(0, 1) == 1) ? a : N'($urandom);
    end else begin
      lo = (sel == 2) ? 0 : $urandom_range(0, N - 1);
      hi = $urandom_range(lo, N - 1);
      kh = (hi < N - 1 && $urandom_range(0, 2) != 0) ? $urandom_range(hi + 1, N - 1) : hi;
      s = mask(lo, hi);
      k = (kh > hi) ? mask(hi + 1, kh) : '0;
      if ($urandom_range(0, 1) == 1) begin a = s | k; b = s; end
      else begin a = s; b = s | k; end
      if (sel == 9) a[$urandom_range(0, N - 1)] ^= 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [N-1:0] a, b;
    n_cmp = 0;
    n_err = 0;
    checking = 1'b0;
    ov_due = BIG;
    last_valid_cyc = -1;
    held = '{mode: 2'b10, mn: 4'd0, val: 4'd0, mx: 4'd0};
    rst_n = 1'b1;
    bus.sample_i = 1'b0;
    bus.leds_i = '0;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    repeat (3) step();
    chk("rst_mode", int'(bus.mode_o), 2);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_overrun", int'(bus.overrun_o), 0);
    rst_n = 1'b1;
    step();

    directed(16'h1FF8, 16'h01F8, 2'b00, 3, 8, 12);
    directed(16'hFFFF, 16'hFFFF, 2'b11, 0, 0, 0);
    directed(16'h0000, 16'h0000, 2'b10, 0, 0, 0);
    directed(16'h0505, 16'h0505, 2'b01, 0, 0, 0);
    directed(16'h00F0, 16'h0F00, 2'b01, 0, 0, 0);
    directed(16'h00FF, 16'h00FF, 2'b00, 0, 7, 7);

    // Strobe during SCAN: flag per build, decode unchanged
    chk("ov_before", int'(bus.overrun_o), 0);
    run_pair(16'h1FF8, 16'h01F8, 1'b1, c);
    chk("ov_mode", int'(bus.mode_o), 0);
    chk("ov_max", int'(bus.max_o), 12);
`ifdef MIN_MAX_DEC_OVERRUN_EN
    chk("ov_flag", int'(bus.overrun_o), 1);
`else
    chk("ov_flag", int'(bus.overrun_o), 0);
`endif

    // Reset at scan index 5 abandons the decode
    strobe(16'h00FF, c);
    strobe(16'h00FF, c);
    while (cyc < c + 6) step();
    rst_n = 1'b0;
    q.delete();
    ov_due = BIG;
    #1;
    chk("arst_mode", int'(bus.mode_o), 2);
    chk("arst_value", int'(bus.value_o), 0);
    chk("arst_max", int'(bus.max_o), 0);
    chk("arst_overrun", int'(bus.overrun_o), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (N + 4) step();
    directed(16'h1FF8, 16'h01F8, 2'b00, 3, 8, 12);

    for (int i = 0; i < 60; i++) begin
      gen_pair(a, b);
      run_pair(a, b, ($urandom_range(0, 3) == 0), c);
    end
    repeat (3) step();
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/min_max_decoder.md
MIN_MAX_DECODER -- requirements
Module: min_max_decoder

Interface
REQ-001 Parameter VALSIZE, default 4, value width; LED bar width N = 2**VALSIZE.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 leds_i  in  N  LED bar driven by the min/max display block.
REQ-006 sample_i  in  1  strobe; leds_i captured in any cycle where sample_i=1, one strobe per osc phase.
REQ-007 min_o  out  VALSIZE  recovered min.
REQ-008 value_o  out  VALSIZE  recovered value.
REQ-009 max_o  out  VALSIZE  recovered max.
REQ-010 mode_o  out  2  00 BAR, 01 INVALID, 10 ALL_OFF, 11 ALL_ON.
REQ-011 valid_o  out  1  one-cycle pulse: min_o/value_o/max_o/mode_o updated.
REQ-012 overrun_o  out  1  sticky flag: strobe arrived while busy.

Function
REQ-013 FSM states: IDLE, CAP_B, SCAN, REPORT.
- IDLE + sample_i: A<=leds_i, go to CAP_B.
- CAP_B + sample_i: B<=leds_i, index<=0, go to SCAN.
- SCAN: one bit per cycle, index 0..N-1; after bit N-1, go to REPORT.
- REPORT: pulse valid_o, go to IDLE.
REQ-014 Latency: second strobe in cycle t -> SCAN in cycles t+1..t+N -> valid_o=1 in cycle t+N+1 only.
REQ-015 Scan bit classes: steady S=A&B, blink K=A^B.
REQ-016 Segment tracker states: NONE, STEADY, BLINK, DONE; it advances only on class changes, in bit order 0 to N-1.
REQ-017 Classification, first match wins:
- A=B=all ones -> ALL_ON.
- A=B=0 -> ALL_OFF.
- S is one contiguous non-empty run [lo..hi], and K is either empty or one contiguous run starting at hi+1 with all K bits in the same phase (K&A=K or K&A=0) -> BAR.
- anything else -> INVALID.
REQ-018 BAR outputs: min_o=lo, value_o=hi, max_o = top bit of K, or hi when K is empty.
REQ-019 A linear-mode bar decodes as BAR with min_o=0, and is not distinguished from linear mode.
REQ-020 For ALL_ON, ALL_OFF and INVALID: min_o, value_o and max_o are 0.
REQ-021 Outputs are registered and hold their value until the next REPORT.
REQ-022 sample_i during SCAN or REPORT is ignored and does not change A, B or the state.
REQ-023 Index counter is VALSIZE+1 bits; no wrap-around inside one scan.

Reset
REQ-024 On rst_ni=0, immediately: state=IDLE, A=B=0, index=0, segment tracker=NONE.
REQ-025 Reset values of outputs: min_o=0, value_o=0, max_o=0, mode_o=10, valid_o=0, overrun_o=0.
REQ-026 Reset during CAP_B or SCAN abandons the decode; no valid_o after release.
REQ-027 First strobe after reset release is treated as the A sample.

Configuration
REQ-028 Macro MIN_MAX_DEC_OVERRUN_EN.
- Defined: overrun_o is set in the cycle after a sample_i arrives in SCAN or REPORT; it stays set until reset.
- Undefined: overrun_o is tied to 0 and no overrun logic is built.

Verification (VALSIZE=4)
REQ-029 A=16'h1FF8, B=16'h01F8 -> valid_o exactly 17 cycles after 2nd strobe, mode_o=00, min_o=3, value_o=8, max_o=12.
REQ-030 A=B=16'hFFFF -> mode_o=11; A=B=16'h0000 -> mode_o=10; min/value/max all 0 in both cases.
REQ-031 A=B=16'h0505 (non-contiguous) -> mode_o=01; A=16'h00F0, B=16'h0F00 -> mode_o=01.
REQ-032 A=B=16'h00FF -> mode_o=00, min_o=0, value_o=7, max_o=7.
REQ-033 Assert rst_ni=0 at SCAN index 5 -> outputs at reset values immediately; no valid_o; a following A/B pair decodes normally.
REQ-034 Strobe in SCAN: with macro -> overrun_o=1 and stays 1; without macro -> overrun_o=0; decode result unaffected in both builds.
